// File: rtl/acs_array.sv
// Add-compare-select array for a rate-1/2 Viterbi decoder: one trellis step per accepted symbol,
// with survivor decisions, MSB-clear normalisation and best-state search, all registered.
module acs_array #(
    parameter int unsigned K   = 3,
    parameter int unsigned G0  = 'o7,
    parameter int unsigned G1  = 'o5,
    parameter int unsigned BMW = 2,
    parameter int unsigned PMW = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       in_valid,
    input  logic [4*BMW-1:0]           bm_in,
    output logic                       dec_valid,
    output logic [(1<<(K-1))-1:0]      dec,
    output logic [K-2:0]               best_state,
    output logic [PMW-1:0]             best_metric,
    output logic                       norm_event,
    output logic [(1<<(K-1))*PMW-1:0]  pm_out
);

    localparam int unsigned NS = 1 << (K - 1);
    localparam int unsigned SW = K - 1;
    localparam logic [K-1:0] G0K = K'(G0);
    localparam logic [K-1:0] G1K = K'(G1);

    logic [NS-1:0][PMW-1:0] r_pm;
    logic [NS-1:0]          r_sv;
    logic [NS-1:0]          r_dec;
    logic                   r_dec_valid;
    logic [SW-1:0]          r_best_state;
    logic [PMW-1:0]         r_best_metric;
    logic                   r_norm_event;

    logic [3:0][BMW-1:0]    w_bm;
    logic [NS-1:0][PMW-1:0] w_new_pm;
    logic [NS-1:0][PMW-1:0] w_fin_pm;
    logic [NS-1:0]          w_new_sv;
    logic [NS-1:0]          w_dec;
    logic                   w_norm;
    logic                   w_found;
    logic [SW-1:0]          w_best_state;
    logic [PMW-1:0]         w_best_metric;

    assign w_bm = bm_in;

    // Per-state butterfly half: predecessors {ns[K-3:0],0/1}, labels from {b, predecessor}.
    for (genvar g = 0; g < NS; g++) begin : g_acs
        localparam int unsigned     P0I = (2 * g) % NS;
        localparam int unsigned     BI  = (g >> (K - 2)) & 1;
        localparam logic [SW-1:0]   P0  = SW'(P0I);
        localparam logic [SW-1:0]   P1  = SW'(P0I + 1);
        localparam logic [K-1:0]    R0  = K'((BI << (K - 1)) | P0I);
        localparam logic [K-1:0]    R1  = K'((BI << (K - 1)) | (P0I + 1));
        localparam logic [1:0]      L0  = {^(R0 & G0K), ^(R0 & G1K)};
        localparam logic [1:0]      L1  = {^(R1 & G0K), ^(R1 & G1K)};

        logic [PMW:0]   w_s0;
        logic [PMW:0]   w_s1;
        logic [PMW-1:0] w_c0;
        logic [PMW-1:0] w_c1;
        logic           w_sel;

        assign w_s0  = {1'b0, r_pm[P0]} + (PMW+1)'(w_bm[L0]);
        assign w_s1  = {1'b0, r_pm[P1]} + (PMW+1)'(w_bm[L1]);
        assign w_c0  = w_s0[PMW] ? {PMW{1'b1}} : w_s0[PMW-1:0];
        assign w_c1  = w_s1[PMW] ? {PMW{1'b1}} : w_s1[PMW-1:0];
        // Predecessor 1 wins only if it alone is valid or strictly cheaper; ties go to 0.
        assign w_sel = r_sv[P1] & (~r_sv[P0] | (w_c0 > w_c1));

        assign w_new_sv[g] = r_sv[P0] | r_sv[P1];
        assign w_dec[g]    = w_sel;
        assign w_new_pm[g] = w_new_sv[g] ? (w_sel ? w_c1 : w_c0) : {PMW{1'b0}};
    end

    // Normalise when every valid metric has its MSB set, then pick the lowest-index minimum.
    always_comb begin
        w_norm        = |w_new_sv;
        w_fin_pm      = w_new_pm;
        w_found       = 1'b0;
        w_best_state  = '0;
        w_best_metric = '0;
        for (int i = 0; i < NS; i++) begin
            if (w_new_sv[SW'(i)] && !w_new_pm[SW'(i)][PMW-1]) begin
                w_norm = 1'b0;
            end
        end
        for (int i = 0; i < NS; i++) begin
            if (w_norm) begin
                w_fin_pm[SW'(i)][PMW-1] = 1'b0;
            end
        end
        for (int i = 0; i < NS; i++) begin
            if (w_new_sv[SW'(i)] && (!w_found || (w_fin_pm[SW'(i)] < w_best_metric))) begin
                w_found       = 1'b1;
                w_best_state  = SW'(i);
                w_best_metric = w_fin_pm[SW'(i)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || start) begin
            r_pm          <= '0;
            r_sv          <= NS'(1);
            r_dec         <= '0;
            r_dec_valid   <= 1'b0;
            r_best_state  <= '0;
            r_best_metric <= '0;
            r_norm_event  <= 1'b0;
        end else if (in_valid) begin
            r_pm          <= w_fin_pm;
            r_sv          <= w_new_sv;
            r_dec         <= w_dec;
            r_dec_valid   <= 1'b1;
            r_best_state  <= w_best_state;
            r_best_metric <= w_best_metric;
            r_norm_event  <= w_norm;
        end else begin
            r_dec_valid   <= 1'b0;
            r_norm_event  <= 1'b0;
        end
    end

    assign pm_out      = r_pm;
    assign dec         = r_dec;
    assign dec_valid   = r_dec_valid;
    assign best_state  = r_best_state;
    assign best_metric = r_best_metric;
    assign norm_event  = r_norm_event;

endmodule
